mmio_timer: RTL

- Memory-mapped timer/GPIO peripheral on the CPU data-memory port, downstream of the ALU result and store-data path, alongside dm_4k.
- Decodes the ALU address. Writes happen on a store; reads are combinational so a load completes in the same cycle.
- The top-level load-data mux selects Rdata when Sel is high.
- Provides a prescaled down-counter with auto-reload, a sticky expiry flag with an interrupt output, and a 16-bit output port.

---
 rtl/mmio_timer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled down-counter with auto-reload, sticky expiry/IRQ and GPIO output.
// Latency: reads are combinational (same-cycle load); writes commit on the rising Clk edge.
// Backpressure: none; every access completes in one cycle, so the peripheral never stalls the CPU.
//
// Ports:
//   Clk, Reset       clock (rising edge), asynchronous active-high reset
//   Addr, Wdata      ALU byte address and store data
//   Wmem             store strobe; a write happens when Wmem && Sel
//   Sel              Addr lies in the 32-byte window at BASE_ADDR
//   Rdata            combinational read data, 0 outside the window or at unmapped offsets
//   Irq              EXP & IRQ_EN
//   Gpio_out         GPIO output register
//   Gpio_in          (only with MMIO_GPIO_IN_EN) input port, synchronised and readable at 0x14
//
// Optional feature macro: MMIO_GPIO_IN_EN
//
// Register map (word offsets): 0x00 CTRL {PRESC[15:8], IRQ_EN[2], AUTO[1], EN[0]},
// 0x04 LOAD, 0x08 COUNT, 0x0C STATUS {EXP[0], W1C}, 0x10 GPIO, 0x14 GPIO_IN (optional).

module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          GPIO_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Addr,
  input  logic [31:0]       Wdata,
  input  logic              Wmem,
  output logic              Sel,
  output logic [31:0]       Rdata,
  output logic              Irq,
`ifdef MMIO_GPIO_IN_EN
  input  logic [GPIO_W-1:0] Gpio_in,
`endif
  output logic [GPIO_W-1:0] Gpio_out
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LOAD   = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_GPIO   = 3'd4;
  localparam logic [2:0] OFF_GPIN   = 3'd5;

  logic              en;
  logic              auto_rl;
  logic              irq_en;
  logic [7:0]        presc;
  logic [7:0]        ps;
  logic [31:0]       load;
  logic [31:0]       count;
  logic              exp_flag;
  logic [GPIO_W-1:0] gpio;

  logic [2:0] offset;
  logic       wr;
  logic       wr_ctrl, wr_load, wr_count, wr_status, wr_gpio;
  logic       tick;
  logic       expire;

  // Byte lane bits are ignored: all accesses are whole words.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^Addr[1:0];

  assign Sel    = (Addr[31:5] == BASE_ADDR[31:5]);
  assign offset = Addr[4:2];
  assign wr     = Wmem && Sel;

  assign wr_ctrl   = wr && (offset == OFF_CTRL);
  assign wr_load   = wr && (offset == OFF_LOAD);
  assign wr_count  = wr && (offset == OFF_COUNT);
  assign wr_status = wr && (offset == OFF_STATUS);
  assign wr_gpio   = wr && (offset == OFF_GPIO);

  // The prescaler wrap is the tick; a tick that finds COUNT at zero is an expiry.
  assign tick   = en && (ps == presc);
  assign expire = tick && (count == 32'd0);

  assign Irq      = exp_flag & irq_en;
  assign Gpio_out = gpio;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      irq_en   <= 1'b0;
      presc    <= 8'd0;
      ps       <= 8'd0;
      load     <= 32'd0;
      count    <= 32'd0;
      exp_flag <= 1'b0;
      gpio     <= '0;
    end else begin
      // A CTRL write restarts the prescale period so a new PRESC starts clean.
      if (wr_ctrl || !en || (ps == presc)) begin
        ps <= 8'd0;
      end else begin
        ps <= ps + 8'd1;
      end

      // CPU write beats the tick. Reload uses LOAD as it was before this edge.
      if (wr_count) begin
        count <= Wdata;
      end else if (tick) begin
        if (count != 32'd0) begin
          count <= count - 32'd1;
        end else if (auto_rl) begin
          count <= load;
        end
      end

      // One-shot expiry stops the timer unless software rewrites EN in the same cycle.
      if (wr_ctrl) begin
        en      <= Wdata[0];
        auto_rl <= Wdata[1];
        irq_en  <= Wdata[2];
        presc   <= Wdata[15:8];
      end else if (expire && !auto_rl) begin
        en <= 1'b0;
      end

      // Setting the flag has priority over a write-1-to-clear in the same cycle.
      if (expire) begin
        exp_flag <= 1'b1;
      end else if (wr_status && Wdata[0]) begin
        exp_flag <= 1'b0;
      end

      if (wr_load) begin
        load <= Wdata;
      end

      if (wr_gpio) begin
        gpio <= Wdata[GPIO_W-1:0];
      end
    end
  end

`ifdef MMIO_GPIO_IN_EN
  logic [GPIO_W-1:0] gin_meta;
  logic [GPIO_W-1:0] gin_sync;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      gin_meta <= '0;
      gin_sync <= '0;
    end else begin
      gin_meta <= Gpio_in;
      gin_sync <= gin_meta;
    end
  end
`endif

  always_comb begin
    Rdata = 32'd0;
    if (Sel) begin
      case (offset)
        OFF_CTRL:   Rdata = {16'd0, presc, 5'd0, irq_en, auto_rl, en};
        OFF_LOAD:   Rdata = load;
        OFF_COUNT:  Rdata = count;
        OFF_STATUS: Rdata = {31'd0, exp_flag};
        OFF_GPIO:   Rdata[GPIO_W-1:0] = gpio;
`ifdef MMIO_GPIO_IN_EN
        OFF_GPIN:   Rdata[GPIO_W-1:0] = gin_sync;
`endif
        default:    Rdata = 32'd0;
      endcase
    end
  end

endmodule
